// File: rtl/convex_feed_arb.sv
// Round-robin two-requester point feeder into a 4-deep FIFO,
// serialized as 5-bit nibbles to a convex-hull engine.
module convex_feed_arb (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       A_VALID,
  input  logic [9:0] A_X,
  input  logic [9:0] A_Y,
  output logic       A_READY,
  input  logic       B_VALID,
  input  logic [9:0] B_X,
  input  logic [9:0] B_Y,
  output logic       B_READY,
  input  logic       READ_PT,
  output logic [4:0] PT_XY,
  input  logic       DROP_V,
  output logic [2:0] FIFO_LVL,
  output logic [7:0] FED_CNT,
  output logic [7:0] DROP_CNT,
  output logic       UNDERRUN
);

  logic [19:0] r_mem [4];
  logic [1:0]  r_wp;
  logic [1:0]  r_rp;
  logic [2:0]  r_lvl;
  logic        r_last;
  logic [19:0] r_sr;
  logic [1:0]  r_nib;
  logic [4:0]  r_pt;
  logic [7:0]  r_fed;
  logic [7:0]  r_drop;
  logic        r_und;

  logic        w_full;
  logic        w_empty;
  logic        w_gnt_a;
  logic        w_gnt_b;
  logic        w_push;
  logic [19:0] w_din;
  logic        w_load;
  logic        w_pop;
  logic [19:0] w_head;
  logic [4:0]  w_nibble;

  assign w_full  = (r_lvl == 3'd4);
  assign w_empty = (r_lvl == 3'd0);

  // r_last names the previous winner; the other side wins a tie
  assign w_gnt_a = A_VALID & (~B_VALID | r_last);
  assign w_gnt_b = B_VALID & (~A_VALID | ~r_last);

  assign A_READY = RST_N & ~w_full & w_gnt_a;
  assign B_READY = RST_N & ~w_full & w_gnt_b;

  assign w_push = A_READY | B_READY;
  assign w_din  = A_READY ? {A_X, A_Y} : {B_X, B_Y};

  assign w_load = READ_PT & (r_nib == 2'd0);
  assign w_pop  = w_load & ~w_empty;
  assign w_head = r_mem[r_rp];

  always_comb begin
    w_nibble = 5'd0;
    unique case (r_nib)
      2'd1:    w_nibble = r_sr[14:10];
      2'd2:    w_nibble = r_sr[9:5];
      2'd3:    w_nibble = r_sr[4:0];
      default: w_nibble = 5'd0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wp] <= w_din;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wp   <= 2'd0;
      r_rp   <= 2'd0;
      r_lvl  <= 3'd0;
      r_last <= 1'b1;
      r_sr   <= 20'd0;
      r_nib  <= 2'd0;
      r_pt   <= 5'd0;
      r_fed  <= 8'd0;
      r_drop <= 8'd0;
      r_und  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wp   <= r_wp + 2'd1;
        r_last <= B_READY;
      end
      if (w_pop) r_rp <= r_rp + 2'd1;
      unique case ({w_push, w_pop})
        2'b10:   r_lvl <= r_lvl + 3'd1;
        2'b01:   r_lvl <= r_lvl - 3'd1;
        default: r_lvl <= r_lvl;
      endcase
      // an empty FIFO at load time feeds a (0,0) substitute point
      if (w_load) begin
        r_sr  <= w_empty ? 20'd0 : w_head;
        r_pt  <= w_empty ? 5'd0 : w_head[19:15];
        r_nib <= 2'd1;
        if (r_fed != 8'hFF) r_fed <= r_fed + 8'd1;
        if (w_empty) r_und <= 1'b1;
      end else if (READ_PT) begin
        r_pt  <= w_nibble;
        r_nib <= r_nib + 2'd1;
      end
      if (DROP_V && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
    end
  end

  assign PT_XY    = r_pt;
  assign FIFO_LVL = r_lvl;
  assign FED_CNT  = r_fed;
  assign DROP_CNT = r_drop;
  assign UNDERRUN = r_und;

endmodule

// File: tb/tb_convex_feed_arb.sv
// Directed bench for convex_feed_arb: inputs change on the falling
// edge, registered outputs are checked on the following falling edge.
module tb_convex_feed_arb;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       A_VALID, B_VALID, READ_PT, DROP_V;
  logic [9:0] A_X, A_Y, B_X, B_Y;
  logic       A_READY, B_READY, UNDERRUN;
  logic [4:0] PT_XY;
  logic [2:0] FIFO_LVL;
  logic [7:0] FED_CNT, DROP_CNT;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  convex_feed_arb dut (
    .CLK(CLK), .RST_N(RST_N),
    .A_VALID(A_VALID), .A_X(A_X), .A_Y(A_Y), .A_READY(A_READY),
    .B_VALID(B_VALID), .B_X(B_X), .B_Y(B_Y), .B_READY(B_READY),
    .READ_PT(READ_PT), .PT_XY(PT_XY), .DROP_V(DROP_V),
    .FIFO_LVL(FIFO_LVL), .FED_CNT(FED_CNT), .DROP_CNT(DROP_CNT),
    .UNDERRUN(UNDERRUN)
  );

  task automatic test_reset;
    RST_N = 1'b1;
    A_VALID = 1'b1; B_VALID = 1'b1; READ_PT = 1'b0; DROP_V = 1'b0;
    A_X = 10'h3FF; A_Y = 10'h001; B_X = 10'h155; B_Y = 10'h2AA;
    #2 RST_N = 1'b0;
    #1;
    total++; if (A_READY !== 1'b0) begin bad++; $display("FAIL rst_a_ready got=%b exp=0", A_READY); end
    total++; if (B_READY !== 1'b0) begin bad++; $display("FAIL rst_b_ready got=%b exp=0", B_READY); end
    total++; if (PT_XY !== 5'd0) begin bad++; $display("FAIL rst_pt got=%h exp=0", PT_XY); end
    total++; if (FIFO_LVL !== 3'd0) begin bad++; $display("FAIL rst_lvl got=%0d exp=0", FIFO_LVL); end
    total++; if (FED_CNT !== 8'd0 || DROP_CNT !== 8'd0) begin bad++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", FED_CNT, DROP_CNT); end
    total++; if (UNDERRUN !== 1'b0) begin bad++; $display("FAIL rst_und got=%b exp=0", UNDERRUN); end
    @(negedge CLK);
    A_VALID = 1'b0; B_VALID = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_arbitration;
    @(negedge CLK);
    A_VALID = 1'b1; A_X = 10'h3FF; A_Y = 10'h001;
    B_VALID = 1'b1; B_X = 10'h155; B_Y = 10'h2AA;
    #1;
    total++; if ({A_READY, B_READY} !== 2'b10) begin bad++; $display("FAIL arb_first got=%b exp=10", {A_READY, B_READY}); end
    @(negedge CLK);
    total++; if (FIFO_LVL !== 3'd1) begin bad++; $display("FAIL arb_lvl1 got=%0d exp=1", FIFO_LVL); end
    #1;
    total++; if ({A_READY, B_READY} !== 2'b01) begin bad++; $display("FAIL arb_second got=%b exp=01", {A_READY, B_READY}); end
    @(negedge CLK);
    total++; if (FIFO_LVL !== 3'd2) begin bad++; $display("FAIL arb_lvl2 got=%0d exp=2", FIFO_LVL); end
    A_VALID = 1'b0; B_VALID = 1'b0;
  endtask

  task automatic test_serializer;
    logic [4:0] e [8];
    e = '{5'h1F, 5'h1F, 5'h00, 5'h01, 5'h0A, 5'h15, 5'h15, 5'h0A};
    READ_PT = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      total++; if (PT_XY !== e[i]) begin bad++; $display("FAIL ser_nib%0d got=%h exp=%h", i, PT_XY, e[i]); end
      if (i == 3) begin
        total++; if (FED_CNT !== 8'd1) begin bad++; $display("FAIL ser_fed1 got=%0d exp=1", FED_CNT); end
        total++; if (FIFO_LVL !== 3'd1) begin bad++; $display("FAIL ser_lvl1 got=%0d exp=1", FIFO_LVL); end
      end
    end
    READ_PT = 1'b0;
    @(negedge CLK);
    total++; if (PT_XY !== 5'h0A) begin bad++; $display("FAIL ser_hold got=%h exp=0a", PT_XY); end
    total++; if (FED_CNT !== 8'd2) begin bad++; $display("FAIL ser_fed2 got=%0d exp=2", FED_CNT); end
    total++; if (FIFO_LVL !== 3'd0) begin bad++; $display("FAIL ser_lvl0 got=%0d exp=0", FIFO_LVL); end
  endtask

  task automatic test_full_fifo;
    logic [4:0] k5;
    logic [4:0] exp;
    A_VALID = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      k5 = 5'(k);
      A_X = {k5, k5}; A_Y = {5'd0, k5};
      @(negedge CLK);
    end
    total++; if (FIFO_LVL !== 3'd4) begin bad++; $display("FAIL full_lvl4 got=%0d exp=4", FIFO_LVL); end
    A_X = {5'd5, 5'd5}; A_Y = {5'd0, 5'd5}; READ_PT = 1'b1;
    #1;
    total++; if (A_READY !== 1'b0) begin bad++; $display("FAIL full_ready0 got=%b exp=0", A_READY); end
    @(negedge CLK);
    total++; if (FIFO_LVL !== 3'd3) begin bad++; $display("FAIL full_lvl3 got=%0d exp=3", FIFO_LVL); end
    total++; if (PT_XY !== 5'd1) begin bad++; $display("FAIL full_nib0 got=%h exp=01", PT_XY); end
    #1;
    total++; if (A_READY !== 1'b1) begin bad++; $display("FAIL full_ready1 got=%b exp=1", A_READY); end
    @(negedge CLK);
    A_VALID = 1'b0;
    total++; if (FIFO_LVL !== 3'd4) begin bad++; $display("FAIL full_relvl4 got=%0d exp=4", FIFO_LVL); end
    total++; if (PT_XY !== 5'd1) begin bad++; $display("FAIL full_nib1 got=%h exp=01", PT_XY); end
    for (int j = 2; j < 20; j++) begin
      @(negedge CLK);
      exp = ((j % 4) == 2) ? 5'd0 : 5'(j / 4 + 1);
      total++; if (PT_XY !== exp) begin bad++; $display("FAIL full_order%0d got=%h exp=%h", j, PT_XY, exp); end
    end
    READ_PT = 1'b0;
    total++; if (FIFO_LVL !== 3'd0) begin bad++; $display("FAIL full_drain got=%0d exp=0", FIFO_LVL); end
    total++; if (FED_CNT !== 8'd7) begin bad++; $display("FAIL full_fed got=%0d exp=7", FED_CNT); end
  endtask

  task automatic test_underrun;
    logic [4:0] e [7];
    e = '{5'h00, 5'h00, 5'h00, 5'h1F, 5'h1F, 5'h00, 5'h01};
    READ_PT = 1'b1;
    A_VALID = 1'b1; A_X = 10'h3FF; A_Y = 10'h001;
    #1;
    total++; if (A_READY !== 1'b1) begin bad++; $display("FAIL und_ready got=%b exp=1", A_READY); end
    @(negedge CLK);
    A_VALID = 1'b0;
    total++; if (PT_XY !== 5'd0) begin bad++; $display("FAIL und_pt got=%h exp=0", PT_XY); end
    total++; if (UNDERRUN !== 1'b1) begin bad++; $display("FAIL und_flag got=%b exp=1", UNDERRUN); end
    total++; if (FED_CNT !== 8'd8) begin bad++; $display("FAIL und_fed got=%0d exp=8", FED_CNT); end
    total++; if (FIFO_LVL !== 3'd1) begin bad++; $display("FAIL und_lvl got=%0d exp=1", FIFO_LVL); end
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      total++; if (PT_XY !== e[i]) begin bad++; $display("FAIL und_nib%0d got=%h exp=%h", i, PT_XY, e[i]); end
    end
    READ_PT = 1'b0;
    total++; if (UNDERRUN !== 1'b1) begin bad++; $display("FAIL und_sticky got=%b exp=1", UNDERRUN); end
    total++; if (FED_CNT !== 8'd9) begin bad++; $display("FAIL und_fed2 got=%0d exp=9", FED_CNT); end
  endtask

  task automatic test_fed_saturation;
    READ_PT = 1'b1;
    repeat (1000) @(negedge CLK);
    READ_PT = 1'b0;
    total++; if (FED_CNT !== 8'd255) begin bad++; $display("FAIL fed_sat got=%0d exp=255", FED_CNT); end
  endtask

  task automatic test_drop_saturation;
    DROP_V = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (i == 253) begin
        total++; if (DROP_CNT !== 8'd254) begin bad++; $display("FAIL drop_254 got=%0d exp=254", DROP_CNT); end
      end
    end
    DROP_V = 1'b0;
    total++; if (DROP_CNT !== 8'd255) begin bad++; $display("FAIL drop_sat got=%0d exp=255", DROP_CNT); end
  endtask

  task automatic test_reset_midpoint;
    logic [4:0] e [4];
    e = '{5'h0A, 5'h15, 5'h15, 5'h0A};
    A_VALID = 1'b1; A_X = 10'h3FF; A_Y = 10'h001;
    @(negedge CLK);
    A_VALID = 1'b0;
    B_VALID = 1'b1; B_X = 10'h2AA; B_Y = 10'h155;
    @(negedge CLK);
    B_VALID = 1'b0; READ_PT = 1'b1;
    @(negedge CLK);
    total++; if (PT_XY !== 5'h1F) begin bad++; $display("FAIL mid_nib0 got=%h exp=1f", PT_XY); end
    @(negedge CLK);
    total++; if (PT_XY !== 5'h1F) begin bad++; $display("FAIL mid_nib1 got=%h exp=1f", PT_XY); end
    READ_PT = 1'b0; A_VALID = 1'b1;
    #2 RST_N = 1'b0;
    #1;
    total++; if (PT_XY !== 5'd0 || FIFO_LVL !== 3'd0) begin bad++; $display("FAIL mid_rst_pt got=%h/%0d exp=0/0", PT_XY, FIFO_LVL); end
    total++; if (FED_CNT !== 8'd0 || DROP_CNT !== 8'd0 || UNDERRUN !== 1'b0) begin bad++; $display("FAIL mid_rst_cnt got=%0d/%0d/%b exp=0/0/0", FED_CNT, DROP_CNT, UNDERRUN); end
    total++; if (A_READY !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b exp=0", A_READY); end
    @(negedge CLK);
    A_VALID = 1'b0;
    RST_N = 1'b1;
    @(negedge CLK);
    B_VALID = 1'b1; B_X = 10'h155; B_Y = 10'h2AA;
    @(negedge CLK);
    B_VALID = 1'b0; READ_PT = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      total++; if (PT_XY !== e[i]) begin bad++; $display("FAIL mid_new%0d got=%h exp=%h", i, PT_XY, e[i]); end
    end
    READ_PT = 1'b0;
    total++; if (FED_CNT !== 8'd1 || UNDERRUN !== 1'b0) begin bad++; $display("FAIL mid_after got=%0d/%b exp=1/0", FED_CNT, UNDERRUN); end
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_serializer();
    test_full_fifo();
    test_underrun();
    test_fed_saturation();
    test_drop_saturation();
    test_reset_midpoint();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/convex_feed_arb.md
CONVEX_FEED_ARB -- requirements
Module: convex_feed_arb

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-002 CLK  in  1  rising-edge clock for all state.
REQ-003 RST_N  in  1  asynchronous active-low reset.
REQ-004 A_VALID  in  1  requester A offers a point.
REQ-005 A_X, A_Y  in  10 each  requester A point coordinates.
REQ-006 A_READY  out  1  requester A point accepted this cycle (combinational grant).
REQ-007 B_VALID, B_X, B_Y, B_READY  same as the A ports, for requester B.
REQ-008 READ_PT  in  1  hull engine requests the next nibble.
REQ-009 PT_XY  out  5  registered nibble to the hull engine.
REQ-010 DROP_V  in  1  hull engine reports one dropped point this cycle.
REQ-011 FIFO_LVL  out  3  point FIFO occupancy, 0..4.
REQ-012 FED_CNT  out  8  points delivered to the engine, saturating at 255.
REQ-013 DROP_CNT  out  8  DROP_V pulses seen, saturating at 255.
REQ-014 UNDERRUN  out  1  sticky flag: the engine asked for a point while the FIFO was empty.

Function
REQ-015 Storage SHALL be a 4-entry FIFO of 20-bit {X,Y} points.
REQ-016 FIFO accept rules:
- at most one push per cycle;
- a push occurs only when FIFO_LVL<4 and the granted requester's VALID=1;
- READY SHALL be 0 whenever FIFO_LVL==4, even if a pop occurs in the same cycle (no bypass).
REQ-017 Round-robin arbiter:
- register LAST (0=A, 1=B), reset to B so that A wins first;
- both valid: grant the requester not equal to LAST;
- one valid: grant that requester;
- LAST updates only on an actual push;
- at most one READY is high per cycle.
REQ-018 Serializer SHALL hold a 20-bit shift register SR and a 2-bit nibble index NIB.
REQ-019 Nibble order for each point SHALL be X[9:5], X[4:0], Y[9:5], Y[4:0].
REQ-020 On a rising edge with READ_PT=1 and NIB==0:
- pop the FIFO head into SR;
- set PT_XY to head X[9:5];
- set NIB to 1.
REQ-021 On a rising edge with READ_PT=1 and NIB!=0:
- set PT_XY to SR nibble NIB;
- set NIB to (NIB+1) mod 4.
REQ-022 With READ_PT=0, PT_XY, NIB and SR SHALL hold; the engine samples PT_XY on the edge after the update.
REQ-023 Underrun, when READ_PT=1, NIB==0 and FIFO_LVL==0 (push in the same cycle excluded):
- load SR with zero and set PT_XY to 0;
- advance NIB to 1 (point (0,0) is delivered);
- set UNDERRUN to 1, which remains set until reset.
REQ-024 FED_CNT SHALL increment at each NIB 0->1 transition, including underrun substitutes, and saturate at 255.
REQ-025 DROP_CNT SHALL increment on each cycle with DROP_V=1 and saturate at 255.
REQ-026 Simultaneous push and pop SHALL leave FIFO_LVL unchanged and preserve FIFO order.
REQ-027 FIFO read and write pointers SHALL be 2-bit and wrap modulo 4.
REQ-028 FIFO_LVL SHALL be registered and reflect the post-edge occupancy.

Reset
REQ-029 RST_N=0 SHALL immediately clear FIFO pointers, FIFO_LVL, NIB, SR, PT_XY, FED_CNT, DROP_CNT and UNDERRUN, and set LAST=B.
REQ-030 A reset asserted mid-point SHALL discard the partial point; after release, the next READ_PT starts at NIB 0.
REQ-031 While RST_N=0, A_READY and B_READY SHALL be 0.

Verification
REQ-032 Arbitration: A and B valid with A=(0x3FF,0x001) and B=(0x155,0x2AA), FIFO empty -> A accepted first, B accepted the next cycle, FIFO_LVL=2.
REQ-033 Serializer: A single point (0x3FF,0x001) followed by 4 READ_PT edges -> PT_XY sequence 0x1F, 0x1F, 0x00, 0x01; FED_CNT=1.
REQ-034 Full FIFO: FIFO full, A valid, READ_PT popping -> A_READY=0 that cycle, then 1 the next cycle; FIFO_LVL goes 4, 3, 4.
REQ-035 Underrun: FIFO empty and READ_PT=1 at NIB 0 -> PT_XY=0, UNDERRUN=1, FED_CNT=1; UNDERRUN stays 1 after later valid points.
REQ-036 Saturation: 300 DROP_V pulses -> DROP_CNT=255.
REQ-037 Reset mid-point: RST_N low after 2 nibbles of a point -> all outputs 0; after release, a new point serializes starting at X[9:5].
